// File: rtl/ssr_select.sv
// Ranks the per-antenna SSR entries of one captured vector, one antenna per clock,
// and holds the index/value of the largest and second-largest entries until taken.
module ssr_select #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ANTENA_NUM = 4,
  localparam int IDX_W      = ($clog2(ANTENA_NUM) > 1) ? $clog2(ANTENA_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [2*ANTENA_NUM*DATA_WIDTH-1:0] ssr_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [IDX_W-1:0]                   best_idx,
  output logic [2*DATA_WIDTH-1:0]            best_ssr,
  output logic [IDX_W-1:0]                   second_idx,
  output logic [2*DATA_WIDTH-1:0]            second_ssr,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int EW = 2 * DATA_WIDTH;
  localparam int VW = ANTENA_NUM * EW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ANTENA_NUM - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [VW-1:0]    ssr_q;
  logic [IDX_W-1:0] cnt_q;

  // Running slots used during the scan; *_vld_q = 0 means the slot is empty.
  logic             run_best_vld_q, run_sec_vld_q;
  logic [IDX_W-1:0] run_best_idx_q, run_sec_idx_q;
  logic [EW-1:0]    run_best_val_q, run_sec_val_q;

  logic             nxt_best_vld, nxt_sec_vld;
  logic [IDX_W-1:0] nxt_best_idx, nxt_sec_idx;
  logic [EW-1:0]    nxt_best_val, nxt_sec_val;

  logic [IDX_W-1:0] best_idx_q, second_idx_q;
  logic [EW-1:0]    best_ssr_q, second_ssr_q;

  logic [EW-1:0]    ent [ANTENA_NUM];
  logic [EW-1:0]    cand;
  logic             accept;
  logic             last_step;

  generate
    for (genvar gi = 0; gi < ANTENA_NUM; gi++) begin : g_ent
      assign ent[gi] = ssr_q[gi*EW +: EW];
    end
  endgenerate

  assign cand      = ent[cnt_q];
  assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
  assign last_step = (state_q == SCAN) && (cnt_q == LAST_IDX);

  // Strict greater-than keeps the lower index ahead on ties.
  always_comb begin
    nxt_best_vld = run_best_vld_q;
    nxt_best_idx = run_best_idx_q;
    nxt_best_val = run_best_val_q;
    nxt_sec_vld  = run_sec_vld_q;
    nxt_sec_idx  = run_sec_idx_q;
    nxt_sec_val  = run_sec_val_q;
    if (!run_best_vld_q || (cand > run_best_val_q)) begin
      nxt_sec_vld  = run_best_vld_q;
      nxt_sec_idx  = run_best_idx_q;
      nxt_sec_val  = run_best_val_q;
      nxt_best_vld = 1'b1;
      nxt_best_idx = cnt_q;
      nxt_best_val = cand;
    end else if (!run_sec_vld_q || (cand > run_sec_val_q)) begin
      nxt_sec_vld  = 1'b1;
      nxt_sec_idx  = cnt_q;
      nxt_sec_val  = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (cnt_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      ssr_q          <= '0;
      cnt_q          <= '0;
      run_best_vld_q <= 1'b0;
      run_best_idx_q <= '0;
      run_best_val_q <= '0;
      run_sec_vld_q  <= 1'b0;
      run_sec_idx_q  <= '0;
      run_sec_val_q  <= '0;
      best_idx_q     <= '0;
      best_ssr_q     <= '0;
      second_idx_q   <= '0;
      second_ssr_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        ssr_q          <= ssr_in;
        cnt_q          <= '0;
        run_best_vld_q <= 1'b0;
        run_sec_vld_q  <= 1'b0;
      end
      if (state_q == SCAN) begin
        run_best_vld_q <= nxt_best_vld;
        run_best_idx_q <= nxt_best_idx;
        run_best_val_q <= nxt_best_val;
        run_sec_vld_q  <= nxt_sec_vld;
        run_sec_idx_q  <= nxt_sec_idx;
        run_sec_val_q  <= nxt_sec_val;
        cnt_q          <= last_step ? '0 : cnt_q + IDX_W'(1);
      end
      // Result registers change only on the edge that enters DONE.
      if (last_step) begin
        best_idx_q   <= nxt_best_idx;
        best_ssr_q   <= nxt_best_val;
        second_idx_q <= nxt_sec_idx;
        second_ssr_q <= nxt_sec_val;
        out_valid_q  <= 1'b1;
      end else if ((state_q == DONE) && out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign best_idx   = best_idx_q;
  assign best_ssr   = best_ssr_q;
  assign second_idx = second_idx_q;
  assign second_ssr = second_ssr_q;

endmodule
